// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg
// Shared core types and constants for the flush controller slice.
//   word                 : 32-bit machine word (PCs, redirect targets)
//   HSV_NUM_STAGES       : default number of pipeline stages under flush control
//   HSV_FLUSH_COUNT_MAX  : saturation value of the completed-flush counter
//   sat_inc16()          : saturating 16-bit increment
package hsv_core_pkg;

  typedef logic [31:0] word;

  localparam int unsigned HSV_NUM_STAGES      = 4;
  localparam logic [15:0] HSV_FLUSH_COUNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == HSV_FLUSH_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/hsv_core_flush_ctrl_if.sv
// hsv_core_flush_ctrl_if
// Fetch redirect handshake between the flush controller and the fetch unit.
//   redirect_valid : redirect request (master -> slave)
//   redirect_pc    : redirect address, stable while redirect_valid is high
//   redirect_ready : fetch accepts the redirect (slave -> master)
interface hsv_core_flush_ctrl_if;

  logic              redirect_valid;
  hsv_core_pkg::word redirect_pc;
  logic              redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );

endinterface

// File: rtl/hsv_core_flush_drain_tracker.sv
// hsv_core_flush_drain_tracker
// Sticky per-stage drain accumulator used while a flush drains the pipeline.
//   clk_core, rst_core_n : core clock, asynchronous active-low reset
//   clear                : clears every sticky bit (start of a drain)
//   sample               : stage_drained is only accumulated while high
//   stage_drained        : per-stage empty indication, may be a one-cycle pulse
//   all_drained          : every stage has been seen drained, including this cycle
module hsv_core_flush_drain_tracker
  import hsv_core_pkg::*;
#(
  parameter int unsigned NUM_STAGES = HSV_NUM_STAGES
) (
  input  logic                  clk_core,
  input  logic                  rst_core_n,
  input  logic                  clear,
  input  logic                  sample,
  input  logic [NUM_STAGES-1:0] stage_drained,
  output logic                  all_drained
);

  logic [NUM_STAGES-1:0] sticky_q;
  logic [NUM_STAGES-1:0] seen;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sticky
    // Clear wins over sample so a stale pulse cannot leak into a new drain.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
        sticky_q[gi] <= 1'b0;
      end else if (clear) begin
        sticky_q[gi] <= 1'b0;
      end else if (sample && stage_drained[gi]) begin
        sticky_q[gi] <= 1'b1;
      end
    end

    // Include the current-cycle pulse so the drain can finish the same cycle
    // the last stage reports empty.
    assign seen[gi] = sticky_q[gi] | (sample & stage_drained[gi]);
  end

  assign all_drained = &seen;

endmodule

// File: rtl/hsv_core_flush_ctrl.sv
// hsv_core_flush_ctrl
// Pipeline flush sequencer: squashes all stages, waits for every stage to
// drain, issues a fetch redirect, then acknowledges the flush upstream.
//   clk_core, rst_core_n : core clock, asynchronous active-low reset
//   flush_req            : flush request (level, held until flush_ack if desired)
//   flush_target         : redirect PC, valid from the second cycle of flush_req
//   flush_ack            : flush complete, held while flush_req stays high
//   stage_flush          : per-stage squash/hold, all-ones outside IDLE
//   stage_drained        : per-stage empty-under-flush indication
//   redir                : fetch redirect handshake (valid/pc/ready)
//   flush_active         : high whenever a flush is in progress
//   flush_count          : saturating count of completed flushes
module hsv_core_flush_ctrl
  import hsv_core_pkg::*;
#(
  parameter int unsigned NUM_STAGES = HSV_NUM_STAGES
) (
  input  logic                  clk_core,
  input  logic                  rst_core_n,
  input  logic                  flush_req,
  input  word                   flush_target,
  output logic                  flush_ack,
  output logic [NUM_STAGES-1:0] stage_flush,
  input  logic [NUM_STAGES-1:0] stage_drained,
  hsv_core_flush_ctrl_if.master redir,
  output logic                  flush_active,
  output logic [15:0]           flush_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_ACK      = 2'd3
  } state_e;

  state_e                state_q;
  logic [NUM_STAGES-1:0] stage_flush_q;
  logic                  flush_ack_q;
  logic                  redirect_valid_q;
  logic                  flush_active_q;
  word                   redirect_pc_q;
  logic [15:0]           flush_count_q;
  logic [15:0]           flush_count_d;
  logic                  drain_clear;
  logic                  drain_sample;
  logic                  all_drained;

  // A new drain starts exactly when IDLE accepts a request.
  assign drain_clear  = (state_q == ST_IDLE) && flush_req;
  assign drain_sample = (state_q == ST_DRAIN);

  assign flush_count_d = sat_inc16(flush_count_q);

  hsv_core_flush_drain_tracker #(
    .NUM_STAGES (NUM_STAGES)
  ) u_drain_tracker (
    .clk_core      (clk_core),
    .rst_core_n    (rst_core_n),
    .clear         (drain_clear),
    .sample        (drain_sample),
    .stage_drained (stage_drained),
    .all_drained   (all_drained)
  );

  // Outputs are registered alongside the state: each transition loads the
  // output values of the state being entered.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q          <= ST_IDLE;
      stage_flush_q    <= '0;
      flush_ack_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_active_q   <= 1'b0;
      redirect_pc_q    <= '0;
      flush_count_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q        <= ST_DRAIN;
            stage_flush_q  <= '1;
            flush_active_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (all_drained) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= flush_target;
          end
        end
        ST_REDIRECT: begin
          if (redir.redirect_ready) begin
            state_q          <= ST_ACK;
            redirect_valid_q <= 1'b0;
            flush_ack_q      <= 1'b1;
          end
        end
        ST_ACK: begin
          // Holding here while flush_req stays high also guarantees a full
          // IDLE cycle before the next request can be accepted.
          if (!flush_req) begin
            state_q        <= ST_IDLE;
            flush_ack_q    <= 1'b0;
            stage_flush_q  <= '0;
            flush_active_q <= 1'b0;
            flush_count_q  <= flush_count_d;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          stage_flush_q    <= 'x;
          flush_ack_q      <= 1'bx;
          redirect_valid_q <= 1'bx;
          flush_active_q   <= 1'bx;
          redirect_pc_q    <= 'x;
          flush_count_q    <= 'x;
        end
      endcase
    end
  end

  assign stage_flush          = stage_flush_q;
  assign flush_ack            = flush_ack_q;
  assign flush_active         = flush_active_q;
  assign flush_count          = flush_count_q;
  assign redir.redirect_valid = redirect_valid_q;
  assign redir.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// tb_hsv_core_flush_ctrl
// Directed bench for hsv_core_flush_ctrl: a cycle-by-cycle vector table for
// the basic and staggered-drain flows, then hand-written sequences for
// backpressure, long ACK hold, reset mid-flush and counter saturation.
module tb_hsv_core_flush_ctrl;
  import hsv_core_pkg::*;

  localparam int unsigned NS = 4;

  logic          clk_core = 1'b0;
  logic          rst_core_n;
  logic          flush_req;
  word           flush_target;
  logic          flush_ack;
  logic [NS-1:0] stage_flush;
  logic [NS-1:0] stage_drained;
  logic          flush_active;
  logic [15:0]   flush_count;

  hsv_core_flush_ctrl_if redir_if ();

  hsv_core_flush_ctrl #(
    .NUM_STAGES (NS)
  ) dut (
    .clk_core      (clk_core),
    .rst_core_n    (rst_core_n),
    .flush_req     (flush_req),
    .flush_target  (flush_target),
    .flush_ack     (flush_ack),
    .stage_flush   (stage_flush),
    .stage_drained (stage_drained),
    .redir         (redir_if),
    .flush_active  (flush_active),
    .flush_count   (flush_count)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic          req;
    logic [31:0]   tgt;
    logic [NS-1:0] dr;
    logic          rdy;
    logic [NS-1:0] e_sf;
    logic          e_rv;
    logic [31:0]   e_pc;
    logic          e_ack;
    logic          e_act;
    logic [15:0]   e_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic req, input logic [31:0] tgt,
                              input logic [NS-1:0] dr, input logic rdy,
                              input logic [NS-1:0] e_sf, input logic e_rv,
                              input logic [31:0] e_pc, input logic e_ack,
                              input logic e_act, input logic [15:0] e_cnt);
    vec_t v;
    v.req = req; v.tgt = tgt; v.dr = dr; v.rdy = rdy;
    v.e_sf = e_sf; v.e_rv = e_rv; v.e_pc = e_pc;
    v.e_ack = e_ack; v.e_act = e_act; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; checks that follow observe
  // the registered outputs of the state occupied during this cycle.
  task automatic cyc(input logic req, input logic [31:0] tgt,
                     input logic [NS-1:0] dr, input logic rdy);
    @(negedge clk_core);
    flush_req               = req;
    flush_target            = tgt;
    stage_drained           = dr;
    redir_if.redirect_ready = rdy;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] pc, input logic [15:0] cnt);
    chk({tag, ".sf"},  32'(stage_flush), 32'h0);
    chk({tag, ".rv"},  32'(redir_if.redirect_valid), 32'h0);
    chk({tag, ".ack"}, 32'(flush_ack), 32'h0);
    chk({tag, ".act"}, 32'(flush_active), 32'h0);
    chk({tag, ".pc"},  redir_if.redirect_pc, pc);
    chk({tag, ".cnt"}, 32'(flush_count), 32'(cnt));
  endtask

  // Minimum-latency flush with req dropped once ACK is reached.
  task automatic do_flush(input logic [31:0] tgt, input logic [15:0] cnt_after);
    cyc(1'b1, 32'h5A5A_5A5A, '0, 1'b1);
    cyc(1'b1, tgt, '1, 1'b1);
    chk("fl.drain_sf", 32'(stage_flush), 32'hF);
    cyc(1'b1, tgt, '0, 1'b1);
    chk("fl.rv", 32'(redir_if.redirect_valid), 32'h1);
    chk("fl.pc", redir_if.redirect_pc, tgt);
    cyc(1'b0, tgt, '0, 1'b1);
    chk("fl.ack", 32'(flush_ack), 32'h1);
    cyc(1'b0, 32'h0, '0, 1'b1);
    chk("fl.ack_drop", 32'(flush_ack), 32'h0);
    chk("fl.cnt", 32'(flush_count), 32'(cnt_after));
    $display("flush tgt=%h count=%h", tgt, flush_count);
  endtask

  initial begin
    // Basic flow: req at row 0, drained at row 1, ready held, req drops at row 5.
    tbl[0]  = mk(1, 32'hDEAD_BEEF, 4'h0, 1, 4'h0, 0, 32'h0,      0, 0, 16'd0);
    tbl[1]  = mk(1, 32'h0000_1000, 4'hF, 1, 4'hF, 0, 32'h0,      0, 1, 16'd0);
    tbl[2]  = mk(1, 32'h0000_1000, 4'h0, 1, 4'hF, 1, 32'h1000,   0, 1, 16'd0);
    tbl[3]  = mk(1, 32'h0000_1000, 4'h0, 1, 4'hF, 0, 32'h1000,   1, 1, 16'd0);
    tbl[4]  = mk(1, 32'h0000_1000, 4'h0, 1, 4'hF, 0, 32'h1000,   1, 1, 16'd0);
    tbl[5]  = mk(0, 32'h0000_1000, 4'h0, 1, 4'hF, 0, 32'h1000,   1, 1, 16'd0);
    tbl[6]  = mk(0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 32'h1000,   0, 0, 16'd1);
    // Staggered drain; drained bits seen in IDLE must not count, req drops mid-drain.
    tbl[7]  = mk(1, 32'hCAFE_0000, 4'hF, 1, 4'h0, 0, 32'h1000,   0, 0, 16'd1);
    tbl[8]  = mk(1, 32'h0000_2000, 4'h0, 1, 4'hF, 0, 32'h1000,   0, 1, 16'd1);
    tbl[9]  = mk(1, 32'h0000_2000, 4'h1, 1, 4'hF, 0, 32'h1000,   0, 1, 16'd1);
    tbl[10] = mk(0, 32'h0000_2000, 4'h0, 1, 4'hF, 0, 32'h1000,   0, 1, 16'd1);
    tbl[11] = mk(0, 32'h0000_2000, 4'h2, 1, 4'hF, 0, 32'h1000,   0, 1, 16'd1);
    tbl[12] = mk(0, 32'h0000_2000, 4'h0, 1, 4'hF, 0, 32'h1000,   0, 1, 16'd1);
    tbl[13] = mk(0, 32'h0000_2000, 4'hC, 1, 4'hF, 0, 32'h1000,   0, 1, 16'd1);
    tbl[14] = mk(0, 32'h0000_2000, 4'h0, 1, 4'hF, 1, 32'h2000,   0, 1, 16'd1);
    tbl[15] = mk(0, 32'h0000_0000, 4'h0, 1, 4'hF, 0, 32'h2000,   1, 1, 16'd1);
    tbl[16] = mk(0, 32'h0000_0000, 4'h0, 1, 4'h0, 0, 32'h2000,   0, 0, 16'd2);

    rst_core_n              = 1'b0;
    flush_req               = 1'b0;
    flush_target            = '0;
    stage_drained           = '0;
    redir_if.redirect_ready = 1'b0;

    repeat (3) @(negedge clk_core);
    chk_idle_outputs("reset", 32'h0, 16'h0);
    rst_core_n = 1'b1;

    // ---------------- table-driven flows ----------------
    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].req, tbl[i].tgt, tbl[i].dr, tbl[i].rdy);
      chk($sformatf("row%0d.sf", i),  32'(stage_flush),             32'(tbl[i].e_sf));
      chk($sformatf("row%0d.rv", i),  32'(redir_if.redirect_valid), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d.pc", i),  redir_if.redirect_pc,         tbl[i].e_pc);
      chk($sformatf("row%0d.ack", i), 32'(flush_ack),               32'(tbl[i].e_ack));
      chk($sformatf("row%0d.act", i), 32'(flush_active),            32'(tbl[i].e_act));
      chk($sformatf("row%0d.cnt", i), 32'(flush_count),             32'(tbl[i].e_cnt));
      $display("row %0d req=%b dr=%h rdy=%b -> sf=%h rv=%b pc=%h ack=%b cnt=%0d",
               i, tbl[i].req, tbl[i].dr, tbl[i].rdy, stage_flush,
               redir_if.redirect_valid, redir_if.redirect_pc, flush_ack, flush_count);
    end

    // ---------------- backpressure: ready low for 5 REDIRECT cycles ----------------
    cyc(1'b1, 32'h1111_1111, '0, 1'b0);
    cyc(1'b1, 32'h0000_3000, '1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'h0BAD_0000 + 32'(k), '0, 1'b0);
      chk($sformatf("bp%0d.rv", k),  32'(redir_if.redirect_valid), 32'h1);
      chk($sformatf("bp%0d.pc", k),  redir_if.redirect_pc,         32'h0000_3000);
      chk($sformatf("bp%0d.ack", k), 32'(flush_ack),               32'h0);
    end
    cyc(1'b1, 32'h0BAD_0005, '0, 1'b1);
    chk("bp.ready_rv",  32'(redir_if.redirect_valid), 32'h1);
    chk("bp.ready_ack", 32'(flush_ack), 32'h0);
    cyc(1'b1, 32'h0BAD_0006, '0, 1'b0);
    chk("bp.ack", 32'(flush_ack), 32'h1);
    chk("bp.rv_drop", 32'(redir_if.redirect_valid), 32'h0);
    $display("backpressure done pc=%h", redir_if.redirect_pc);

    // ---------------- wait-for-IRQ: ACK held 100 cycles ----------------
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 32'h0, '0, 1'b0);
      chk("irq.ack", 32'(flush_ack), 32'h1);
      chk("irq.sf",  32'(stage_flush), 32'hF);
    end
    cyc(1'b0, 32'h0, '0, 1'b0);
    chk("irq.last_ack", 32'(flush_ack), 32'h1);
    cyc(1'b0, 32'h0, '0, 1'b0);
    chk_idle_outputs("irq.exit", 32'h0000_3000, 16'd3);
    $display("wait-for-irq done count=%0d", flush_count);

    // ---------------- reset during REDIRECT ----------------
    cyc(1'b1, 32'h0, '0, 1'b0);
    cyc(1'b1, 32'h0000_4000, '1, 1'b0);
    cyc(1'b1, 32'h0000_4000, '0, 1'b0);
    chk("rst.pre_rv", 32'(redir_if.redirect_valid), 32'h1);
    #2 rst_core_n = 1'b0;
    #1 chk_idle_outputs("rst.async", 32'h0, 16'h0);
    cyc(1'b0, 32'h0, '0, 1'b1);
    chk_idle_outputs("rst.held", 32'h0, 16'h0);
    rst_core_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 32'h0, '0, 1'b1);
      chk_idle_outputs($sformatf("rst.after%0d", k), 32'h0, 16'h0);
    end
    do_flush(32'h0000_5000, 16'd1);

    // ---------------- counter saturation ----------------
    force dut.flush_count_q = 16'hFFFE;
    @(negedge clk_core);
    release dut.flush_count_q;
    @(negedge clk_core);
    chk("sat.preload", 32'(flush_count), 32'h0000_FFFE);
    do_flush(32'h0000_6000, 16'hFFFF);
    do_flush(32'h0000_7000, 16'hFFFF);
    do_flush(32'h0000_8000, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsv_core_flush_ctrl.md
HSV_CORE_FLUSH_CTRL -- requirements
Module: hsv_core_flush_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of pipeline stages flushed and drained per flush.
REQ-002 SHALL have port clk_core, input, 1 bit: core clock.
REQ-003 SHALL have port rst_core_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port flush_req, input, 1 bit: flush request from the control/status FSM.
REQ-005 SHALL have port flush_target, input, word (32 bits): redirect PC; not valid on the first cycle of flush_req, stable afterwards.
REQ-006 SHALL have port flush_ack, output, 1 bit: flush complete, back to the control/status FSM.
REQ-007 SHALL have port stage_flush, output, NUM_STAGES bits: per-stage squash/hold.
REQ-008 SHALL have port stage_drained, input, NUM_STAGES bits: per-stage "empty under flush" indication, may pulse.
REQ-009 SHALL have port redirect_valid, output, 1 bit: fetch redirect request.
REQ-010 SHALL have port redirect_pc, output, word (32 bits): fetch redirect address.
REQ-011 SHALL have port redirect_ready, input, 1 bit: fetch accepts the redirect.
REQ-012 SHALL have port flush_active, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port flush_count, output, 16 bits: completed-flush counter.

Function
REQ-014 SHALL implement the FSM states IDLE, DRAIN, REDIRECT and ACK, fully registered, with outputs decoded from state.
REQ-015 In IDLE with flush_req=1, the FSM SHALL go to DRAIN next cycle and clear all sticky drained bits.
REQ-016 In IDLE with flush_req=0, the FSM SHALL remain in IDLE.
REQ-017 stage_flush SHALL be all-ones in DRAIN, REDIRECT and ACK, and zero in IDLE.
REQ-018 In DRAIN, each sticky bit i SHALL set when stage_drained[i]=1 and stay set until the next DRAIN entry.
REQ-019 DRAIN SHALL last at least one cycle.
REQ-020 DRAIN SHALL exit to REDIRECT on the first cycle where (sticky | stage_drained) is all-ones.
REQ-021 On the DRAIN->REDIRECT transition, flush_target SHALL be registered into redirect_pc.
REQ-022 redirect_pc SHALL hold that value until the next capture.
REQ-023 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc SHALL be stable; on redirect_ready=1 the FSM SHALL go to ACK next cycle.
REQ-024 redirect_valid SHALL be 0 outside REDIRECT.
REQ-025 In ACK, flush_ack SHALL be 1.
REQ-026 ACK SHALL remain while flush_req=1, including indefinitely while the upstream waits for an interrupt.
REQ-027 When flush_req=0 in ACK, the FSM SHALL return to IDLE next cycle, dropping flush_ack and stage_flush together.
REQ-028 If flush_req drops during DRAIN or REDIRECT, the sequence SHALL still complete; ACK then lasts exactly one cycle.
REQ-029 In IDLE, flush_req is not sampled in the same cycle the FSM leaves ACK, so a new flush starts no earlier than one cycle in IDLE.
REQ-030 flush_count SHALL increment by 1 on each ACK->IDLE transition and saturate at 16'hFFFF.
REQ-031 Minimum latency SHALL be: flush_req rises at cycle 0 -> stage_flush at cycle 1 -> redirect_valid at cycle 2 (drained at cycle 1) -> flush_ack at cycle 3 (ready at cycle 2).
REQ-032 Unreachable state encodings SHALL drive all outputs to X in simulation and return to IDLE.

Reset
REQ-033 While rst_core_n=0: state=IDLE, stage_flush=0, flush_ack=0, redirect_valid=0, flush_active=0, redirect_pc=0, flush_count=0, sticky bits=0.
REQ-034 Reset asserted mid-flush SHALL abort immediately to the reset values; no redirect and no ack SHALL be issued.
REQ-035 After reset release, the first flush_req SHALL be handled normally.

Structure
REQ-036 word SHALL come from hsv_core_pkg.
REQ-037 The state enum SHALL be local to the module.
REQ-038 The default NUM_STAGES constant SHALL live in hsv_core_pkg.
REQ-039 The sticky drain accumulator MAY be a sub-module, hsv_core_flush_drain_tracker (NUM_STAGES-wide, inputs clear/sample, output all_drained); all other logic SHALL stay in one module.

Verification
REQ-040 Basic: flush_req=1 at cycle 0, flush_target=32'h0000_1000 from cycle 1, all stage_drained=1 at cycle 1, redirect_ready=1 -> redirect_valid with redirect_pc=32'h0000_1000 at cycle 2; flush_ack at cycle 3; flush_req=0 at cycle 5 -> IDLE at cycle 6; flush_count=1.
REQ-041 Staggered drain: stage_drained pulses bit0 at cycle 2, bit1 at cycle 4, bits2-3 at cycle 6 (each one cycle only) -> REDIRECT entered at cycle 7.
REQ-042 Backpressure: redirect_ready=0 for 5 cycles -> redirect_valid held and redirect_pc unchanged throughout; flush_ack not asserted until one cycle after ready.
REQ-043 Wait-for-IRQ: flush_req held 100 cycles -> flush_ack stays 1 and stage_flush stays all-ones; flush_req drops -> both 0 next cycle.
REQ-044 Reset mid-operation: rst_core_n pulsed low during REDIRECT -> all outputs at reset values; flush_count=0.
REQ-045 Saturation: preload flush_count to 16'hFFFE and run 3 flushes -> flush_count reads 16'hFFFF.
